cam_cfg_seq: RTL and testbench

Camera configuration sequencer that walks a register-init table and drives the I2C master with one register-write transaction per entry. It runs on `clk_100` after `i2c_reset` release, between the external init-table ROM and `i2c_top`. It also interprets delay and end opcodes, retries NACKed writes, and reports done or error status to the top level.

---
 rtl/cam_cfg_pkg.sv | 32 +++
 rtl/ms_tick_gen.sv | 36 +++
 rtl/cam_cfg_seq.sv | 169 ++++++++++++++++
 tb/tb_cam_cfg_seq.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cam_cfg_pkg.sv
// Shared types for the camera configuration sequencer, its init-table ROM and bench.
// A table word is {op, register address, data}.
package cam_cfg_pkg;

    localparam int CFG_ENTRY_W = 26;

    typedef enum logic [1:0] {
        OP_WRITE = 2'b00,
        OP_DELAY = 2'b01,
        OP_END   = 2'b10,
        OP_RSVD  = 2'b11
    } cfg_op_e;

    // 'reg' is a reserved word, so the register-address field is called addr
    typedef struct packed {
        cfg_op_e     op;
        logic [15:0] addr;
        logic [7:0]  dat;
    } cfg_entry_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_REQ,
        S_GAP,
        S_DELAY,
        S_DONE,
        S_ERROR
    } cfg_state_e;

endpackage

// File: rtl/ms_tick_gen.sv
// Free-running 1 ms tick: one-cycle pulse every CLK_HZ/1000 clocks.
// restart zeroes the phase so a delay starts on a fresh millisecond boundary.
module ms_tick_gen #(
    parameter int CLK_HZ = 100_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic restart,
    output logic tick
);

    localparam int DIV = (CLK_HZ / 1000 > 0) ? CLK_HZ / 1000 : 1;
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic          wrap;

    assign wrap = (cnt_q == CW'(DIV - 1));
    assign tick = wrap && !restart;

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (restart || wrap) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/cam_cfg_seq.sv
// Walks the camera init table and issues one I2C register write per WRITE entry,
// honouring DELAY/END opcodes, retrying NACKs and reporting done/error.
module cam_cfg_seq
    import cam_cfg_pkg::*;
#(
    parameter int         NUM_ENTRIES = 64,
    parameter logic [6:0] DEV_ADDR    = 7'h36,
    parameter int         MAX_RETRY   = 3,
    parameter int         CLK_HZ      = 100_000_000,
    localparam int        IDXW        = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    output logic [IDXW-1:0]        tbl_idx,
    input  logic [CFG_ENTRY_W-1:0] tbl_entry,
    output logic                   i2c_req,
    output logic [6:0]             i2c_dev,
    output logic [15:0]            i2c_reg,
    output logic [7:0]             i2c_dat,
    input  logic                   i2c_done,
    input  logic                   i2c_nack,
    output logic                   busy,
    output logic                   done,
    output logic                   error,
    output logic [IDXW-1:0]        err_idx
);

    localparam int RW = $clog2(MAX_RETRY + 1);

    cfg_state_e      state_q, state_d;
    logic [IDXW-1:0] idx_q, idx_d;
    logic [IDXW-1:0] err_idx_q, err_idx_d;
    logic [15:0]     reg_q, reg_d;
    logic [7:0]      dat_q, dat_d;
    logic [RW-1:0]   retry_q, retry_d;
    logic [15:0]     ms_q, ms_d;
    logic            adv_q, adv_d;
    logic            advance;
    logic            tick_restart;
    logic            ms_tick;
    cfg_entry_t      entry;

    assign entry = tbl_entry;

    ms_tick_gen #(
        .CLK_HZ (CLK_HZ)
    ) u_tick (
        .clk     (clk),
        .reset   (reset),
        .restart (tick_restart),
        .tick    (ms_tick)
    );

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        err_idx_d    = err_idx_q;
        reg_d        = reg_q;
        dat_d        = dat_q;
        retry_d      = retry_q;
        ms_d         = ms_q;
        adv_d        = adv_q;
        advance      = 1'b0;
        tick_restart = 1'b0;

        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) begin
                    state_d   = S_FETCH;
                    idx_d     = '0;
                    err_idx_d = '0;
                    retry_d   = '0;
                    adv_d     = 1'b0;
                end
            end
            S_FETCH: state_d = S_DECODE;
            S_DECODE: begin
                case (entry.op)
                    OP_WRITE: begin
                        reg_d   = entry.addr;
                        dat_d   = entry.dat;
                        state_d = S_REQ;
                    end
                    OP_DELAY: begin
                        ms_d         = entry.addr;
                        tick_restart = 1'b1;
                        state_d      = S_DELAY;
                    end
                    default: state_d = S_DONE;
                endcase
            end
            S_REQ: begin
                if (i2c_done) begin
                    if (!i2c_nack) begin
                        retry_d = '0;
                        adv_d   = 1'b1;
                        state_d = S_GAP;
                    end else if (retry_q < RW'(MAX_RETRY)) begin
                        retry_d = retry_q + RW'(1);
                        adv_d   = 1'b0;
                        state_d = S_GAP;
                    end else begin
                        err_idx_d = idx_q;
                        state_d   = S_ERROR;
                    end
                end
            end
            // Every finished transaction passes through GAP so i2c_req always drops for a cycle
            S_GAP: begin
                if (adv_q) begin
                    advance = 1'b1;
                end else begin
                    state_d = S_REQ;
                end
            end
            S_DELAY: begin
                if (ms_q == 16'd0 || (ms_tick && ms_q == 16'd1)) begin
                    advance = 1'b1;
                end else if (ms_tick) begin
                    ms_d = ms_q - 16'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (advance) begin
            if (idx_q == IDXW'(NUM_ENTRIES - 1)) begin
                state_d = S_DONE;
            end else begin
                idx_d   = idx_q + IDXW'(1);
                state_d = S_FETCH;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            err_idx_q <= '0;
            reg_q     <= '0;
            dat_q     <= '0;
            retry_q   <= '0;
            ms_q      <= '0;
            adv_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            err_idx_q <= err_idx_d;
            reg_q     <= reg_d;
            dat_q     <= dat_d;
            retry_q   <= retry_d;
            ms_q      <= ms_d;
            adv_q     <= adv_d;
        end
    end

    assign tbl_idx = idx_q;
    assign err_idx = err_idx_q;
    assign i2c_req = (state_q == S_REQ);
    assign i2c_dev = DEV_ADDR;
    assign i2c_reg = reg_q;
    assign i2c_dat = dat_q;
    assign busy    = !(state_q == S_IDLE || state_q == S_DONE || state_q == S_ERROR);
    assign done    = (state_q == S_DONE);
    assign error   = (state_q == S_ERROR);

endmodule

// File: tb/tb_cam_cfg_seq.sv
// Directed bench for cam_cfg_seq: registered table ROM plus an I2C slave model
// that answers each request two cycles after it rises, with a per-entry NACK plan.
module tb_cam_cfg_seq;
    import cam_cfg_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  tbl_idx;
    logic [1:0]  err_idx;
    logic [25:0] tbl_entry;
    logic        i2c_req;
    logic [6:0]  i2c_dev;
    logic [15:0] i2c_reg;
    logic [7:0]  i2c_dat;
    logic        i2c_done = 1'b0;
    logic        i2c_nack = 1'b0;
    logic        busy, done, error;

    cfg_entry_t  rom [4];
    int          nack_plan [4];
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;

    int          n = 0;
    logic [15:0] req_reg [64];
    logic [7:0]  req_dat [64];
    int          req_cyc [64];
    int          req_idx [64];
    int          done_cyc [64];
    logic        in_txn = 1'b0;
    int          wcnt = 0;
    int          cons = 0;
    int          last_idx = 0;
    logic        stable_bad = 1'b0;

    cam_cfg_seq #(
        .NUM_ENTRIES (4),
        .DEV_ADDR    (7'h36),
        .MAX_RETRY   (3),
        .CLK_HZ      (1000)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .tbl_idx   (tbl_idx),
        .tbl_entry (tbl_entry),
        .i2c_req   (i2c_req),
        .i2c_dev   (i2c_dev),
        .i2c_reg   (i2c_reg),
        .i2c_dat   (i2c_dat),
        .i2c_done  (i2c_done),
        .i2c_nack  (i2c_nack),
        .busy      (busy),
        .done      (done),
        .error     (error),
        .err_idx   (err_idx)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) tbl_entry <= rom[tbl_idx];

    always @(negedge clk) begin
        i2c_done = 1'b0;
        i2c_nack = 1'b0;
        if (reset || !i2c_req) begin
            in_txn = 1'b0;
        end else if (!in_txn) begin
            in_txn = 1'b1;
            wcnt   = 0;
            if (n < 64) begin
                req_reg[n] = i2c_reg;
                req_dat[n] = i2c_dat;
                req_cyc[n] = cyc;
                req_idx[n] = int'(tbl_idx);
            end
            n++;
            if (int'(tbl_idx) != last_idx) begin
                cons     = 0;
                last_idx = int'(tbl_idx);
            end
        end else begin
            wcnt++;
            if (n > 0 && n <= 64 && (i2c_reg !== req_reg[n-1] || i2c_dat !== req_dat[n-1]))
                stable_bad = 1'b1;
            if (wcnt == 2) begin
                i2c_done = 1'b1;
                if (nack_plan[last_idx] < 0 || cons < nack_plan[last_idx]) begin
                    i2c_nack = 1'b1;
                    cons++;
                end else begin
                    cons = 0;
                end
                if (n <= 64) done_cyc[n-1] = cyc;
            end
        end
    end

    function automatic cfg_entry_t mk(input cfg_op_e op, input logic [15:0] a, input logic [7:0] d);
        cfg_entry_t e;
        e.op   = op;
        e.addr = a;
        e.dat  = d;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_start(output int s);
        @(negedge clk);
        start = 1'b1;
        s = cyc;
        @(negedge clk);
        start = 1'b0;
        chk("start_busy", busy, 1);
        chk("start_idx", tbl_idx, 0);
        chk("start_done_clr", done, 0);
        chk("start_err_clr", error, 0);
        chk("start_erridx_clr", err_idx, 0);
    endtask

    task automatic wait_idle(output int e);
        logic found = 1'b0;
        e = -1;
        for (int i = 0; i < 400 && !found; i++) begin
            @(negedge clk);
            if (!busy) begin
                found = 1'b1;
                e = cyc;
            end
        end
        chk("idle_reached", found, 1);
    endtask

    initial begin
        int   s, e, base;
        logic seen;

        for (int i = 0; i < 4; i++) begin
            rom[i] = mk(OP_END, 16'h0, 8'h0);
            nack_plan[i] = 0;
        end

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_req", i2c_req, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        chk("rst_idx", tbl_idx, 0);
        chk("rst_erridx", err_idx, 0);
        chk("rst_reg", i2c_reg, 0);
        chk("rst_dat", i2c_dat, 0);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("idle_no_start", busy, 0);

        // Two writes then END
        rom[0] = mk(OP_WRITE, 16'h0100, 8'h00);
        rom[1] = mk(OP_WRITE, 16'h0103, 8'h01);
        rom[2] = mk(OP_END, 16'h0, 8'h0);
        base = n;
        do_start(s);
        wait_idle(e);
        chk("t1_count", n - base, 2);
        chk("t1_reg0", req_reg[base], 16'h0100);
        chk("t1_dat0", req_dat[base], 8'h00);
        chk("t1_reg1", req_reg[base+1], 16'h0103);
        chk("t1_dat1", req_dat[base+1], 8'h01);
        chk("t1_first_req_lat", req_cyc[base], s + 3);
        chk("t1_ack_to_next_req", req_cyc[base+1], done_cyc[base] + 4);
        chk("t1_end_to_done", e, done_cyc[base+1] + 4);
        chk("t1_done", done, 1);
        chk("t1_error", error, 0);
        chk("t1_dev", i2c_dev, 7'h36);

        // Write, 5 ms delay (1 cycle per ms), write, END
        rom[0] = mk(OP_WRITE, 16'h3034, 8'h1A);
        rom[1] = mk(OP_DELAY, 16'd5, 8'h00);
        rom[2] = mk(OP_WRITE, 16'h0100, 8'h01);
        rom[3] = mk(OP_END, 16'h0, 8'h0);
        base = n;
        do_start(s);
        wait_idle(e);
        chk("t2_count", n - base, 2);
        chk("t2_reg0", req_reg[base], 16'h3034);
        chk("t2_dat0", req_dat[base], 8'h1A);
        chk("t2_reg1", req_reg[base+1], 16'h0100);
        chk("t2_dat1", req_dat[base+1], 8'h01);
        // ack T: GAP, FETCH, DECODE, 5 DELAY cycles, FETCH, DECODE, REQ at T+11
        chk("t2_delay_timing", req_cyc[base+1], done_cyc[base] + 11);
        chk("t2_done", done, 1);

        // Entry 1 NACKs twice then ACKs
        rom[0] = mk(OP_WRITE, 16'h0100, 8'h00);
        rom[1] = mk(OP_WRITE, 16'h0103, 8'h01);
        rom[2] = mk(OP_END, 16'h0, 8'h0);
        nack_plan[1] = 2;
        base = n;
        do_start(s);
        wait_idle(e);
        chk("t3_count", n - base, 4);
        chk("t3_retry_idx", req_idx[base+3], 1);
        chk("t3_retry_reg", req_reg[base+3], 16'h0103);
        chk("t3_gap1", req_cyc[base+2], done_cyc[base+1] + 2);
        chk("t3_gap2", req_cyc[base+3], done_cyc[base+2] + 2);
        chk("t3_done", done, 1);
        chk("t3_error", error, 0);
        nack_plan[1] = 0;

        // Entry 2 always NACKs -> error after 4 attempts
        rom[0] = mk(OP_WRITE, 16'h0100, 8'h00);
        rom[1] = mk(OP_WRITE, 16'h0101, 8'h11);
        rom[2] = mk(OP_WRITE, 16'h0102, 8'h22);
        rom[3] = mk(OP_END, 16'h0, 8'h0);
        nack_plan[2] = -1;
        base = n;
        do_start(s);
        wait_idle(e);
        chk("t4_count", n - base, 6);
        chk("t4_last_idx", req_idx[base+5], 2);
        chk("t4_last_gap", req_cyc[base+5], done_cyc[base+4] + 2);
        chk("t4_error", error, 1);
        chk("t4_done", done, 0);
        chk("t4_erridx", err_idx, 2);
        repeat (3) @(negedge clk);
        chk("t4_error_held", error, 1);
        nack_plan[2] = 0;
        base = n;
        do_start(s);
        wait_idle(e);
        chk("t4_rerun_count", n - base, 3);
        chk("t4_rerun_reg0", req_reg[base], 16'h0100);
        chk("t4_rerun_done", done, 1);

        // No END in a 4-entry table; start mid-run ignored
        rom[0] = mk(OP_WRITE, 16'h0200, 8'hA0);
        rom[1] = mk(OP_WRITE, 16'h0201, 8'hA1);
        rom[2] = mk(OP_WRITE, 16'h0202, 8'hA2);
        rom[3] = mk(OP_WRITE, 16'h0203, 8'hA3);
        base = n;
        do_start(s);
        repeat (10) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle(e);
        chk("t5_count", n - base, 4);
        chk("t5_reg3", req_reg[base+3], 16'h0203);
        chk("t5_dat3", req_dat[base+3], 8'hA3);
        chk("t5_idx3", req_idx[base+3], 3);
        chk("t5_last_to_done", e, done_cyc[base+3] + 2);
        chk("t5_done", done, 1);
        repeat (3) @(negedge clk);
        chk("t5_no_wrap", tbl_idx, 3);
        chk("t5_done_held", done, 1);

        // Reset while a request is outstanding
        rom[0] = mk(OP_WRITE, 16'h0100, 8'h00);
        rom[1] = mk(OP_WRITE, 16'h0103, 8'h01);
        rom[2] = mk(OP_END, 16'h0, 8'h0);
        base = n;
        do_start(s);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (i2c_req) seen = 1'b1;
        end
        chk("t6_req_seen", seen, 1);
        #2 reset = 1'b1;
        #1;
        chk("t6_req_drop", i2c_req, 0);
        chk("t6_busy_drop", busy, 0);
        chk("t6_done_drop", done, 0);
        chk("t6_error_drop", error, 0);
        chk("t6_idx_drop", tbl_idx, 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        chk("t6_stay_idle", busy, 0);
        chk("t6_no_req", i2c_req, 0);
        chk("t6_count", n - base, 1);
        base = n;
        do_start(s);
        wait_idle(e);
        chk("t6_rerun_count", n - base, 2);
        chk("t6_rerun_done", done, 1);

        chk("reg_dat_stable", stable_bad, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
